// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready requesters.
// Optional burst locking (hold grant until req_last) is enabled by FIFO_ARB_BURST_LOCK_EN.
module fifo_wr_arbiter #(
   parameter  int unsigned NUM_REQ    = 4,
   parameter  int unsigned DATA_WIDTH = 32,
   localparam int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          clr,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_write_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   input  logic                          fifo_full,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
   logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

   logic [NUM_REQ-1:0]    hi_mask;
   logic [NUM_REQ-1:0]    hi_req;
   logic [ID_WIDTH-1:0]   pick_id;
   logic                  g_valid;
   logic [DATA_WIDTH-1:0] g_data;
   logic                  burst_done;
   logic [ID_WIDTH-1:0]   next_ptr;

   // Lowest valid index at/after rr_ptr, else lowest valid index overall (wrap-around).
   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         hi_mask[i] = (ID_WIDTH'(i) >= rr_ptr_q);
      end
      hi_req  = req_valid & hi_mask;
      pick_id = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) pick_id = ID_WIDTH'(i);
      end
      if (|hi_req) begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hi_req[i]) pick_id = ID_WIDTH'(i);
         end
      end
   end

   // Select the granted requester's valid and data slice.
   always_comb begin
      g_valid = 1'b0;
      g_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == ID_WIDTH'(i)) begin
            g_valid = req_valid[i];
            g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef FIFO_ARB_BURST_LOCK_EN
   always_comb begin
      burst_done = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == ID_WIDTH'(i)) burst_done = req_last[i];
      end
   end
`else
   logic unused_last;
   assign unused_last = ^req_last;
   assign burst_done  = 1'b1;
`endif

   assign next_ptr = (grant_id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_WIDTH'(1);
   assign grant_id = grant_id_q;

   always_comb begin
      state_d       = state_q;
      grant_id_d    = grant_id_q;
      rr_ptr_d      = rr_ptr_q;
      req_ready     = '0;
      fifo_write_en = 1'b0;
      fifo_data_in  = '0;
      busy          = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               grant_id_d = pick_id;
               state_d    = ST_GRANT;
            end
         end
         ST_GRANT: begin
            busy          = 1'b1;
            fifo_data_in  = g_data;
            fifo_write_en = g_valid & ~fifo_full;
            for (int i = 0; i < NUM_REQ; i++) begin
               req_ready[i] = (grant_id_q == ID_WIDTH'(i)) & ~fifo_full;
            end
            if (fifo_write_en && burst_done) begin
               state_d  = ST_IDLE;
               rr_ptr_d = next_ptr;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= ST_IDLE;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

endmodule
